// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the program counter, addresses the combinational instruction memory,
// and loads the IF/ID pipeline register for decode. Redirects from EX squash
// the wrong-path fetch with a bubble; stalls from the hazard unit freeze the stage.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   // Next sequential word address; wraps modulo 2^32 by construction.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      pc_inc = pc + 32'd4;
   endfunction

   // Force a redirect target onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      word_align = {addr[31:2], 2'b00};
   endfunction

   logic [31:0] pc_p0;
   logic [31:0] instr_p1;
   logic [31:0] pc_p1;
   logic [31:0] pc4_p1;
   logic        vld_p1;
   logic        err_q;
   logic [31:0] cnt_q;
   logic        advance;

   // A normal advance happens only when neither reset, redirect nor stall wins.
   assign advance = !reset && !redirect && !stall;

   // ---- stage p0: program counter drives instruction memory ----
   assign imem_addr = pc_p0;

   // Program counter update with reset > redirect > stall > advance priority.
   always_ff @(posedge clk) begin
      if (reset)
         pc_p0 <= RESET_PC;
      else if (redirect)
         pc_p0 <= word_align(redirect_pc);
      else if (!stall)
         pc_p0 <= pc_inc(pc_p0);
   end

   // ---- stage p1: IF/ID pipeline register ----
   // IF/ID load: bubble on redirect (pc fields hold), capture fetch on advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_p1 <= NOP_INSTR;
         pc_p1    <= 32'd0;
         pc4_p1   <= 32'd0;
         vld_p1   <= 1'b0;
      end else if (redirect) begin
         instr_p1 <= NOP_INSTR;
         vld_p1   <= 1'b0;
      end else if (!stall) begin
         instr_p1 <= imem_instr;
         pc_p1    <= pc_p0;
         pc4_p1   <= pc_inc(pc_p0);
         vld_p1   <= 1'b1;
      end
   end

   // Sticky flag for any redirect target that was not word-aligned.
   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (redirect && (redirect_pc[1:0] != 2'b00))
         err_q <= 1'b1;
   end

   // Count of valid instructions delivered into IF/ID; wraps naturally.
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= 32'd0;
      else if (advance)
         cnt_q <= cnt_q + 32'd1;
   end

   assign if_id_instr    = instr_p1;
   assign if_id_pc       = pc_p1;
   assign if_id_pc_plus4 = pc4_p1;
   assign if_id_valid    = vld_p1;
   assign misalign_err   = err_q;
   assign fetch_count    = cnt_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipelined MIPS processor. Holds the program counter and drives the address of the combinational instruction memory. Captures the returned word into the IF/ID pipeline register for the decode stage. Handles load-use stalls from the hazard unit and taken branch/jump redirects from EX, squashing the wrong-path instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID contents this cycle
- redirect  in  1  taken branch/jump resolved downstream
- redirect_pc  in  32  target PC for redirect
- imem_addr  out  32  byte address to instruction memory (= current PC)
- imem_instr  in  32  instruction word returned combinationally for imem_addr
- if_id_instr  out  32  registered instruction to decode
- if_id_pc  out  32  registered PC of if_id_instr
- if_id_pc_plus4  out  32  registered if_id_pc + 4
- if_id_valid  out  1  1 = real instruction, 0 = bubble
- misalign_err  out  1  sticky: a redirect target had nonzero bits [1:0]
- fetch_count  out  32  number of instructions delivered into IF/ID as valid

## Operation
- State: pc (32), IF/ID register (instr, pc, pc_plus4, valid), misalign_err, fetch_count.
- imem_addr = pc, purely combinational; imem_instr is sampled on the same edge.
- Per-edge priority: reset > redirect > stall > normal advance.
- Reset: pc <= RESET_PC; if_id_instr <= NOP_INSTR; if_id_pc <= 0; if_id_pc_plus4 <= 0; if_id_valid <= 0; misalign_err <= 0; fetch_count <= 0.
- Redirect (stall ignored): pc <= {redirect_pc[31:2], 2'b00}. IF/ID <= bubble (instr NOP_INSTR, valid 0, pc/pc_plus4 hold previous values). The instruction fetched this cycle is dropped. If redirect_pc[1:0] != 0, misalign_err <= 1 and stays 1 until reset.
- Stall (no redirect): pc and the entire IF/ID register hold; fetch_count holds.
- Normal: pc <= pc + 4. IF/ID <= {imem_instr, pc, pc + 4, valid 1}. fetch_count <= fetch_count + 1.
- Arithmetic: all PC math is 32-bit modulo 2^32. pc 32'hFFFF_FFFC advances to 32'h0000_0000. pc_plus4 wraps identically. fetch_count wraps to 0 after 32'hFFFF_FFFF.
- fetch_count increments only on a normal advance, never on stall, redirect, or reset.
- pc is always word-aligned; bits [1:0] are never nonzero.

## Timing
- Latency: the instruction at pc appears on if_id_instr one clock after the edge on which pc was current.
- Throughput: one instruction per cycle when stall = 0 and redirect = 0.
- First cycle after reset release: imem_addr = RESET_PC and if_id_valid = 0. After the next edge, if_id_instr = mem[RESET_PC] with if_id_valid = 1.
- Redirect penalty: one bubble cycle out of this stage. The target instruction is in IF/ID two edges after redirect is sampled.
- Stall held N cycles: imem_addr and all IF/ID outputs are constant for N cycles. Advance resumes on the first edge with stall = 0.
- Reset asserted mid-stream (including during stall or redirect): the reset values take effect at that edge.
- Inputs are sampled only at the rising edge of clk; no combinational path from stall or redirect to any output.

## Test plan
- Reset then free-run with memory words 0x00221820, 0x00253822, 0x00329812, 0x000819E5 at byte addresses 0, 4, 8, 12 -> imem_addr steps 0, 4, 8, 12. if_id_instr follows one cycle later with if_id_pc 0, 4, 8, 12 and if_id_pc_plus4 4, 8, 12, 16. fetch_count = 4 after four advances.
- Stall for 2 cycles while pc = 8 -> imem_addr stays 8, if_id_instr stays 0x00253822 with if_id_pc = 4, fetch_count frozen. On release, if_id_instr becomes 0x00329812.
- redirect with redirect_pc = 0x40 while pc = 12 -> next cycle imem_addr = 0x40, if_id_valid = 0, if_id_instr = NOP_INSTR. The following cycle if_id_pc = 0x40 with if_id_valid = 1.
- redirect and stall asserted together, redirect_pc = 0x20 -> redirect wins: pc = 0x20 and a bubble in IF/ID. redirect_pc = 0x22 -> pc = 0x20 and misalign_err = 1, still 1 after 10 further cycles, cleared only by reset.
- Load pc = 0xFFFF_FFFC via redirect, then advance -> if_id_pc = 0xFFFF_FFFC, if_id_pc_plus4 = 0x0000_0000, imem_addr = 0x0000_0000.
- Assert reset for one cycle during a stall at pc = 0x10 -> after that edge, pc = RESET_PC, if_id_valid = 0, fetch_count = 0, misalign_err = 0.
